// File: rtl/xpb_lut_ram.sv
// xpb_lut_ram: runtime-programmable table of reduction constants (j*2^k mod N).
// The table is streamed in LOAD_W bits at a time over a ready/valid load port.
// It then serves NUM_CH independent registered lookups per cycle.
// Entry 0 is never stored; any lookup of select 0 returns zero.
module xpb_lut_ram #(
   parameter int DATA_W = 1024,
   parameter int SEL_W  = 5,
   parameter int NUM_CH = 4,
   parameter int LOAD_W = 64
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       load_start,
   input  logic                       load_valid,
   output logic                       load_ready,
   input  logic [LOAD_W-1:0]          load_data,
   output logic                       load_done,
   output logic                       tbl_ready,
   input  logic [NUM_CH-1:0]          lu_valid,
   input  logic [NUM_CH*SEL_W-1:0]    lu_sel,
   output logic [NUM_CH-1:0]          lu_out_valid,
   output logic [NUM_CH*DATA_W-1:0]   lu_data,
   output logic [NUM_CH-1:0]          lu_err
);

   localparam int WPE    = DATA_W / LOAD_W;
   localparam int DEPTH  = 1 << SEL_W;
   localparam int WCNT_W = (WPE > 1) ? $clog2(WPE) : 1;

   localparam logic [WCNT_W-1:0] WORD_LAST  = WCNT_W'(WPE - 1);
   localparam logic [SEL_W-1:0]  ENTRY_LAST = SEL_W'(DEPTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_COMMIT
   } state_t;

   state_t              state_q;
   state_t              state_d;
   logic [WCNT_W-1:0]   word_cnt;
   logic [SEL_W-1:0]    entry_cnt;
   logic [DATA_W-1:0]   asm_q;
   logic [DATA_W-1:0]   asm_d;
   logic [DATA_W-1:0]   tbl [DEPTH];
   logic                accept;
   logic                word_last;
   logic                entry_last;
   logic                start_load;

   assign accept     = load_ready & load_valid;
   assign word_last  = (word_cnt == WORD_LAST);
   assign entry_last = (entry_cnt == ENTRY_LAST);
   assign start_load = (state_q == ST_IDLE) & load_start;

   // Next-state and load-port handshake outputs.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
      state_d    = state_q;
      load_ready = 1'b0;
      load_done  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (load_start) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            load_ready = 1'b1;
            if (accept && word_last && entry_last) state_d = ST_COMMIT;
         end
         ST_COMMIT: begin
            load_done = 1'b1;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Entry assembly: word w lands at bits [w*LOAD_W +: LOAD_W], so word 0 is the LSBs.
   always_comb begin
      asm_d = asm_q;
      asm_d[word_cnt*LOAD_W +: LOAD_W] = load_data;
   end

   // FSM state, load counters and the table-valid flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: sequential state is updated with non-blocking assignments so every register samples pre-edge values.
         state_q   <= ST_IDLE;
         word_cnt  <= '0;
         entry_cnt <= '0;
         tbl_ready <= 1'b0;
      end else begin
         state_q <= state_d;
         if (start_load) begin
            word_cnt  <= '0;
            entry_cnt <= SEL_W'(1);
            tbl_ready <= 1'b0;
         end else begin
            if (accept) begin
               if (word_last) begin
                  word_cnt  <= '0;
                  entry_cnt <= entry_cnt + SEL_W'(1);
               end else begin
                  word_cnt <= word_cnt + WCNT_W'(1);
               end
            end
            if (state_q == ST_COMMIT) tbl_ready <= 1'b1;
         end
      end
   end

   // Assembly register and table storage, written only from the load path.
   always_ff @(posedge clk) begin
      // NOTE: the table and assembly register are plain storage with no reset, so they map onto RAM/flops without a clear network.
      if (accept) begin
         asm_q <= asm_d;
         if (word_last) tbl[entry_cnt] <= asm_d;
      end
   end

   // Per-channel registered lookup: valid and error always follow the request; data holds when idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lu_out_valid <= '0;
         lu_err       <= '0;
         lu_data      <= '0;
      end else begin
         lu_out_valid <= lu_valid;
         lu_err       <= lu_valid & {NUM_CH{~tbl_ready}};
         for (int c = 0; c < NUM_CH; c++) begin
            if (lu_valid[c]) begin
               if (tbl_ready && (lu_sel[c*SEL_W +: SEL_W] != '0)) begin
                  lu_data[c*DATA_W +: DATA_W] <= tbl[lu_sel[c*SEL_W +: SEL_W]];
               end else begin
                  lu_data[c*DATA_W +: DATA_W] <= '0;
               end
            end
         end
      end
   end

endmodule
